// File: rtl/reg_pipe_d_if.sv
// Bundle of the delay line's control, input and output signals.
// The master side drives stimulus and the slave side is the delay line itself.
interface reg_pipe_d_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SELW  = $clog2(DEPTH + 1)
) ();
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [SELW-1:0]  delay_sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  count;

    modport master (
        output en, flush, in_valid, in_data, delay_sel,
        input  out_valid, out_data, count
    );

    modport slave (
        input  en, flush, in_valid, in_data, delay_sel,
        output out_valid, out_data, count
    );
endinterface

// File: rtl/reg_pipe_d.sv
// Stallable WIDTH x DEPTH delay line with per-stage valid flags, run-time output
// tap selection, synchronous flush and a running count of valid stages.
module reg_pipe_d #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    reg_pipe_d_if.slave bus
);

    // Index 0 holds stage 1 (newest word); index DEPTH-1 holds stage DEPTH.
    logic [WIDTH-1:0] stage_data_p [0:DEPTH-1];
    logic [DEPTH-1:0] stage_vld_p;
    logic [SELW-1:0]  count_p;
    logic [SELW-1:0]  count_nxt;
    logic [SELW-1:0]  tap;
    logic [WIDTH-1:0] out_data_c;
    logic             out_valid_c;

    function automatic logic [SELW-1:0] clamp_tap(input logic [SELW-1:0] sel);
        logic [SELW-1:0] t;
        if (sel == '0)
            t = SELW'(1);
        else if (sel > SELW'(DEPTH))
            t = SELW'(DEPTH);
        else
            t = sel;
        return t;
    endfunction

    // Count stays in 0..DEPTH, so modular SELW-bit arithmetic is exact here.
    always_comb begin
        count_nxt = count_p + SELW'(bus.in_valid) - SELW'(stage_vld_p[DEPTH-1]);
    end

    // Stage register chain: reset > flush > en > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++)
                stage_data_p[k] <= '0;
            stage_vld_p <= '0;
            count_p     <= '0;
        end else if (bus.flush) begin
            stage_vld_p <= '0;
            count_p     <= '0;
        end else if (bus.en) begin
            stage_data_p[0] <= bus.in_data;
            stage_vld_p[0]  <= bus.in_valid;
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage_data_p[k] <= stage_data_p[k-1];
                stage_vld_p[k]  <= stage_vld_p[k-1];
            end
            count_p <= count_nxt;
        end
    end

    // Output tap: purely combinational from stored stages and delay_sel.
    always_comb begin
        tap         = clamp_tap(bus.delay_sel);
        out_data_c  = stage_data_p[0];
        out_valid_c = stage_vld_p[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == SELW'(k + 1)) begin
                out_data_c  = stage_data_p[k];
                out_valid_c = stage_vld_p[k];
            end
        end
    end

    assign bus.out_data  = out_data_c;
    assign bus.out_valid = out_valid_c;
    assign bus.count     = count_p;

endmodule

// File: tb/tb_reg_pipe_d.sv
// Directed and randomized checks of reg_pipe_d against a queue-based model of
// the delay line.
module tb_reg_pipe_d;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SELW  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_pipe_d_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) bus ();

    reg_pipe_d #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model: queue of {valid, data}, front = stage 1, back = stage DEPTH.
    logic [WIDTH:0] mq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic f,
                              input logic v, input logic [WIDTH-1:0] d);
        if (r) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        end else if (f) begin
            for (int i = 0; i < DEPTH; i++) mq[i][WIDTH] = 1'b0;
        end else if (e) begin
            mq.push_front({v, d});
            void'(mq.pop_back());
        end
    endtask

    function automatic int exp_tap(input logic [SELW-1:0] s);
        if (s == 0) return 1;
        if (int'(s) > DEPTH) return DEPTH;
        return int'(s);
    endfunction

    function automatic int exp_count();
        int c = 0;
        foreach (mq[i]) c += int'(mq[i][WIDTH]);
        return c;
    endfunction

    task automatic check_model(input string tag);
        int t;
        t = exp_tap(bus.delay_sel);
        check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'(mq[t-1][WIDTH]));
        check_eq({tag, "_data"}, 32'(bus.out_data), 32'(mq[t-1][WIDTH-1:0]));
        check_eq({tag, "_cnt"}, 32'(bus.count), 32'(exp_count()));
    endtask

    // Drive one cycle of inputs, clock it, update model, then check.
    task automatic step(input string tag, input logic r, input logic e, input logic f,
                        input logic v, input logic [WIDTH-1:0] d, input logic [SELW-1:0] s);
        reset         = r;
        bus.en        = e;
        bus.flush     = f;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.delay_sel = s;
        @(posedge clk);
        model_edge(r, e, f, v, d);
        #1;
        check_model(tag);
    endtask

    task automatic set_sel(input logic [SELW-1:0] s);
        bus.delay_sel = s;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] a_words [4];
        reset = 1'b1; bus.en = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.delay_sel = SELW'(1);
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        a_words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        // Reset with active inputs
        for (int i = 0; i < 2; i++) begin
            step("reset", 1, 1, 0, 1, 8'hFF, SELW'(3));
            check_eq("reset_vld", 32'(bus.out_valid), 0);
            check_eq("reset_data", 32'(bus.out_data), 0);
            check_eq("reset_cnt", 32'(bus.count), 0);
        end

        // Stream 0x11,0x22,0x33 at delay_sel=3
        step("stream_t0", 0, 1, 0, 1, 8'h11, SELW'(3));
        step("stream_t1", 0, 1, 0, 1, 8'h22, SELW'(3));
        step("stream_t2", 0, 1, 0, 1, 8'h33, SELW'(3));
        check_eq("stream_t2_data", 32'(bus.out_data), 32'h11);
        check_eq("stream_t2_vld", 32'(bus.out_valid), 1);
        check_eq("stream_t2_cnt", 32'(bus.count), 3);
        step("stream_t3", 0, 1, 0, 0, 8'h00, SELW'(3));
        check_eq("stream_t3_data", 32'(bus.out_data), 32'h22);
        step("stream_t4", 0, 1, 0, 0, 8'h00, SELW'(3));
        check_eq("stream_t4_data", 32'(bus.out_data), 32'h33);
        check_eq("stream_t4_vld", 32'(bus.out_valid), 1);
        step("stream_t5", 0, 1, 0, 0, 8'h00, SELW'(3));
        step("stream_t6", 0, 1, 0, 0, 8'h00, SELW'(3));
        check_eq("stream_t6_cnt", 32'(bus.count), 0);

        // Stall of two cycles after t1
        step("stall_rst", 1, 0, 0, 0, 8'h00, SELW'(3));
        step("stall_t0", 0, 1, 0, 1, 8'h11, SELW'(3));
        step("stall_t1", 0, 1, 0, 1, 8'h22, SELW'(3));
        step("stall_h0", 0, 0, 0, 1, 8'h99, SELW'(3));
        check_eq("stall_h0_cnt", 32'(bus.count), 2);
        step("stall_h1", 0, 0, 0, 1, 8'h99, SELW'(3));
        check_eq("stall_h1_cnt", 32'(bus.count), 2);
        check_eq("stall_h1_vld", 32'(bus.out_valid), 0);
        step("stall_t2", 0, 1, 0, 1, 8'h33, SELW'(3));
        check_eq("stall_t2_data", 32'(bus.out_data), 32'h11);
        step("stall_t3", 0, 1, 0, 0, 8'h00, SELW'(3));
        check_eq("stall_t3_data", 32'(bus.out_data), 32'h22);
        step("stall_t4", 0, 1, 0, 0, 8'h00, SELW'(3));
        check_eq("stall_t4_data", 32'(bus.out_data), 32'h33);

        // Flush with a word presented on the same edge
        step("fl_w0", 0, 1, 0, 1, 8'h55, SELW'(1));
        step("fl_w1", 0, 1, 0, 1, 8'h66, SELW'(1));
        step("fl_w2", 0, 1, 0, 1, 8'h77, SELW'(1));
        step("flush", 0, 1, 1, 1, 8'h44, SELW'(1));
        check_eq("flush_cnt", 32'(bus.count), 0);
        for (int s = 1; s <= DEPTH; s++) begin
            set_sel(SELW'(s));
            check_eq("flush_tap_vld", 32'(bus.out_valid), 0);
            check_eq("flush_no44", 32'(bus.out_data == 8'h44), 0);
        end
        step("fl_after", 0, 1, 0, 1, 8'h5A, SELW'(1));
        check_eq("fl_after_data", 32'(bus.out_data), 32'h5A);
        check_eq("fl_after_vld", 32'(bus.out_valid), 1);

        // Clamp and live tap change on a full pipe of A1..A4
        foreach (a_words[i]) step("fill", 0, 1, 0, 1, a_words[i], SELW'(1));
        step("clamp_hold", 0, 0, 0, 0, 8'h00, SELW'(0));
        check_eq("clamp_sel0", 32'(bus.out_data), 32'hA4);
        set_sel(SELW'(7));
        check_eq("clamp_sel7", 32'(bus.out_data), 32'hA1);
        set_sel(SELW'(1));
        check_eq("tap_sel1", 32'(bus.out_data), 32'hA4);
        set_sel(SELW'(4));
        check_eq("tap_sel4", 32'(bus.out_data), 32'hA1);
        check_model("tap_sel4_model");

        // Alternating valid gaps from an empty pipe
        step("gap_flush", 0, 0, 1, 0, 8'h00, SELW'(2));
        for (int i = 0; i < 8; i++) begin
            step("gap", 0, 1, 0, logic'(i % 2 == 0), 8'(8'hC0 + i), SELW'(2));
            check_eq("gap_cnt_le2", 32'(bus.count <= 2), 1);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 1)),
                 WIDTH'($urandom),
                 SELW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
